// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the packet-level PE input arbiter.
package pe_arb_pkg;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned LEN_MSB = LEN_LSB + LEN_W - 1;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StBody
  } arb_state_e;

endpackage

// File: rtl/pe_rr_sel.sv
// Two-way round-robin pick; the pointer moves past the side that just completed a packet.
module pe_rr_sel
  import pe_arb_pkg::*;
(
  input  logic CLK,
  input  logic SYS_RST,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic done_i,
  input  logic done_src_i,
  output logic grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = SRC_A;
    if (req_a_i && req_b_i) begin
      grant_o = ptr_q;
    end else if (req_b_i) begin
      grant_o = SRC_B;
    end
  end

  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      ptr_q <= SRC_A;
    end else if (done_i) begin
      ptr_q <= ~done_src_i;
    end
  end

endmodule

// File: rtl/pe_pkt_arb.sv
// Packet-level round-robin arbiter merging two header+payload streams onto one PE input.
module pe_pkt_arb #(
  parameter int unsigned DW    = 64,
  parameter int unsigned LEN_W = 16
) (
  input  logic          CLK,
  input  logic          SYS_RST,
  input  logic [DW-1:0] DA,
  input  logic          DA_VALID,
  output logic          DA_BP,
  input  logic [DW-1:0] DB,
  input  logic          DB_VALID,
  output logic          DB_BP,
  output logic [DW-1:0] Q,
  output logic          Q_VALID,
  input  logic          Q_BP,
  output logic          Q_SRC,
  output logic          Q_HDR,
  output logic          Q_LAST,
  output logic          BUSY,
  output logic [31:0]   PKT_CNT_A,
  output logic [31:0]   PKT_CNT_B
);
  import pe_arb_pkg::*;

  arb_state_e       state_q;
  logic             grant_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      pkt_cnt_a_q, pkt_cnt_a_d;
  logic [31:0]      pkt_cnt_b_q, pkt_cnt_b_d;

  logic             busy;
  logic [DW-1:0]    d_sel;
  logic             v_sel;
  logic             xfer;
  logic             last;
  logic             done;
  logic             rr_pick;
  logic [LEN_W-1:0] hdr_len;

  pe_rr_sel u_rr (
    .CLK        (CLK),
    .SYS_RST    (SYS_RST),
    .req_a_i    (DA_VALID),
    .req_b_i    (DB_VALID),
    .done_i     (done),
    .done_src_i (grant_q),
    .grant_o    (rr_pick)
  );

  always_comb begin
    busy    = (state_q != StIdle);
    d_sel   = (grant_q == SRC_B) ? DB : DA;
    v_sel   = (grant_q == SRC_B) ? DB_VALID : DA_VALID;
    hdr_len = d_sel[LEN_LSB +: LEN_W];
    xfer    = busy && v_sel && !Q_BP;
    last    = ((state_q == StHdr) && (hdr_len == '0)) ||
              ((state_q == StBody) && (cnt_q == LEN_W'(1)));
    done    = xfer && last;

    Q       = busy ? d_sel : '0;
    Q_VALID = busy && v_sel;
    Q_SRC   = busy ? grant_q : SRC_A;
    Q_HDR   = (state_q == StHdr);
    Q_LAST  = last;
    BUSY    = busy;
    // Only the granted side ever sees the PE's backpressure; the other is held off.
    DA_BP   = (busy && grant_q == SRC_A) ? Q_BP : 1'b1;
    DB_BP   = (busy && grant_q == SRC_B) ? Q_BP : 1'b1;

    pkt_cnt_a_d = pkt_cnt_a_q;
    pkt_cnt_b_d = pkt_cnt_b_q;
    if (done && grant_q == SRC_A) pkt_cnt_a_d = pkt_cnt_a_q + 32'd1;
    if (done && grant_q == SRC_B) pkt_cnt_b_d = pkt_cnt_b_q + 32'd1;

    PKT_CNT_A = pkt_cnt_a_q;
    PKT_CNT_B = pkt_cnt_b_q;
  end

  always_ff @(posedge CLK) begin
    if (SYS_RST) begin
      state_q     <= StIdle;
      grant_q     <= SRC_A;
      cnt_q       <= '0;
      pkt_cnt_a_q <= '0;
      pkt_cnt_b_q <= '0;
    end else begin
      pkt_cnt_a_q <= pkt_cnt_a_d;
      pkt_cnt_b_q <= pkt_cnt_b_d;
      unique case (state_q)
        StIdle: begin
          if (DA_VALID || DB_VALID) begin
            grant_q <= rr_pick;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (xfer) begin
            cnt_q   <= hdr_len;
            state_q <= (hdr_len == '0) ? StIdle : StBody;
          end
        end
        StBody: begin
          if (xfer) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_pkt_arb.sv
// Directed bench for pe_pkt_arb: single packet, contention, zero length, stall, reset, wrap.
module tb_pe_pkt_arb;

  logic        CLK = 1'b0;
  logic        SYS_RST;
  logic [63:0] DA, DB, Q;
  logic        DA_VALID, DB_VALID, DA_BP, DB_BP;
  logic        Q_VALID, Q_BP, Q_SRC, Q_HDR, Q_LAST, BUSY;
  logic [31:0] PKT_CNT_A, PKT_CNT_B;

  int checks = 0;
  int errors = 0;

  pe_pkt_arb dut (
    .CLK       (CLK),
    .SYS_RST   (SYS_RST),
    .DA        (DA),
    .DA_VALID  (DA_VALID),
    .DA_BP     (DA_BP),
    .DB        (DB),
    .DB_VALID  (DB_VALID),
    .DB_BP     (DB_BP),
    .Q         (Q),
    .Q_VALID   (Q_VALID),
    .Q_BP      (Q_BP),
    .Q_SRC     (Q_SRC),
    .Q_HDR     (Q_HDR),
    .Q_LAST    (Q_LAST),
    .BUSY      (BUSY),
    .PKT_CNT_A (PKT_CNT_A),
    .PKT_CNT_B (PKT_CNT_B)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int len, input logic [47:0] tag);
    return {tag, 16'(len)};
  endfunction

  function automatic logic [63:0] pay(input int i, input logic [47:0] tag);
    return {tag ^ 48'h5A5A_A5A5_0F0F, 16'(i)};
  endfunction

  task automatic drive(input bit s, input logic [63:0] d, input logic v);
    if (s) begin DB = d; DB_VALID = v; end
    else   begin DA = d; DA_VALID = v; end
  endtask

  function automatic logic bp_of(input bit s);
    return s ? DB_BP : DA_BP;
  endfunction

  task automatic idle_all();
    @(negedge CLK);
    DA_VALID = 0; DB_VALID = 0; DA = '0; DB = '0; Q_BP = 0;
    #1;
    chk("idle_busy", BUSY, 0);
    chk("idle_qvalid", Q_VALID, 0);
  endtask

  // Arbitration cycle followed by header and payload beats, one per clock with Q_BP low.
  task automatic run_pkt(input bit s, input int len, input logic [47:0] tag,
                         input logic ov, input logic [63:0] oh);
    @(negedge CLK);
    drive(s, hdr(len, tag), 1'b1);
    drive(!s, oh, ov);
    #1;
    chk("arb_busy", BUSY, 0);
    chk("arb_qvalid", Q_VALID, 0);
    chk("arb_bp", {DA_BP, DB_BP, Q_HDR, Q_LAST, Q_SRC}, 5'b11000);
    @(negedge CLK);
    #1;
    chk("hdr_q", Q, hdr(len, tag));
    chk("hdr_flags", {Q_VALID, Q_HDR, Q_LAST, Q_SRC}, {1'b1, 1'b1, len == 0, s});
    chk("hdr_bp", {bp_of(s), bp_of(!s)}, 2'b01);
    for (int i = 1; i <= len; i++) begin
      @(negedge CLK);
      drive(s, pay(i, tag), 1'b1);
      #1;
      chk("body_q", Q, pay(i, tag));
      chk("body_flags", {Q_VALID, Q_HDR, Q_LAST, Q_SRC, BUSY}, {1'b1, 1'b0, i == len, s, 1'b1});
      chk("body_bp", {bp_of(s), bp_of(!s)}, 2'b01);
    end
  endtask

  initial begin
    SYS_RST = 1; DA = '0; DB = '0; DA_VALID = 0; DB_VALID = 0; Q_BP = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_outs", {DA_BP, DB_BP, Q_VALID, Q_HDR, Q_LAST, Q_SRC, BUSY}, 7'b1100000);
    chk("rst_cnt", {PKT_CNT_A, PKT_CNT_B}, 64'd0);
    SYS_RST = 0;

    // Single A packet, LEN=3
    run_pkt(1'b0, 3, 48'hA1, 1'b0, 64'd0);
    idle_all();
    chk("single_cnt_a", PKT_CNT_A, 32'd1);

    // Contention from reset: A, B, A, B
    @(negedge CLK); SYS_RST = 1;
    @(negedge CLK); SYS_RST = 0;
    run_pkt(1'b0, 2, 48'hA2, 1'b1, hdr(2, 48'hB2));
    run_pkt(1'b1, 2, 48'hB2, 1'b1, hdr(2, 48'hA3));
    run_pkt(1'b0, 2, 48'hA3, 1'b1, hdr(2, 48'hB3));
    run_pkt(1'b1, 2, 48'hB3, 1'b1, hdr(2, 48'hA4));
    idle_all();
    chk("cont_cnt", {PKT_CNT_A, PKT_CNT_B}, {32'd2, 32'd2});

    // Zero-length B packet
    run_pkt(1'b1, 0, 48'hB4, 1'b0, 64'd0);
    idle_all();
    chk("zero_cnt_b", PKT_CNT_B, 32'd3);

    // Backpressure: A LEN=4, 5 stall cycles before payload 2
    run_pkt(1'b0, 1, 48'hA5, 1'b0, 64'd0);  // LEN=1 warm-up, ends with payload 1 as last
    idle_all();
    @(negedge CLK); drive(1'b0, hdr(4, 48'hA6), 1'b1);
    @(negedge CLK); #1;
    chk("bp_hdr", Q, hdr(4, 48'hA6));
    @(negedge CLK); drive(1'b0, pay(1, 48'hA6), 1'b1); #1;
    chk("bp_p1", {Q_LAST, Q_HDR}, 2'b00);
    @(negedge CLK); drive(1'b0, pay(2, 48'hA6), 1'b1); Q_BP = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_stall_q", Q, pay(2, 48'hA6));
      chk("bp_stall_flags", {DA_BP, DB_BP, Q_VALID, Q_LAST, BUSY}, 5'b11101);
      @(negedge CLK);
    end
    Q_BP = 0;
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, pay(i, 48'hA6), 1'b1);
      #1;
      chk("bp_resume_q", Q, pay(i, 48'hA6));
      chk("bp_resume_last", {Q_LAST, DA_BP}, {i == 4, 1'b0});
      @(negedge CLK);
    end
    DA_VALID = 0; #1;
    chk("bp_done", {BUSY, PKT_CNT_A}, {1'b0, 32'd4});

    // Reset mid-packet after 2 of 6 beats
    @(negedge CLK); drive(1'b0, hdr(5, 48'hA7), 1'b1);
    @(negedge CLK);
    @(negedge CLK); drive(1'b0, pay(1, 48'hA7), 1'b1);
    @(negedge CLK); drive(1'b0, pay(2, 48'hA7), 1'b1); SYS_RST = 1;
    @(negedge CLK); SYS_RST = 0; DA_VALID = 0; #1;
    chk("mrst_busy", {BUSY, Q_VALID}, 2'b00);
    chk("mrst_cnt", {PKT_CNT_A, PKT_CNT_B}, 64'd0);
    chk("mrst_ptr", dut.u_rr.ptr_q, 0);
    run_pkt(1'b1, 2, 48'hB8, 1'b0, 64'd0);
    idle_all();
    chk("mrst_cnt_b", {PKT_CNT_A, PKT_CNT_B}, {32'd0, 32'd1});

    // Counter wrap
    @(negedge CLK); force dut.pkt_cnt_a_q = 32'hFFFF_FFFF;
    @(negedge CLK); release dut.pkt_cnt_a_q;
    @(negedge CLK); #1;
    chk("wrap_pre", PKT_CNT_A, 32'hFFFF_FFFF);
    run_pkt(1'b0, 1, 48'hA9, 1'b0, 64'd0);
    idle_all();
    chk("wrap_post", PKT_CNT_A, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
